// File: rtl/dp_ram_initiator_pkg.sv
// Shared types and lane-steering helpers for the port-B RAM bus initiator.
package dp_ram_initiator_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sext;
    logic [1:0] off;
    logic       err;
  } pending_t;

  // Size 3 is never legal, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return 4'b0011 << off;
      SIZE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_B:  return {4{data[7:0]}};
      SIZE_H:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] rdata_ext(input logic [1:0] size, input logic sext,
                                            input logic [1:0] off, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  return {{24{sext & sh[7]}}, sh[7:0]};
      SIZE_H:  return {{16{sext & sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dp_ram_initiator_fifo.sv
// Small synchronous response FIFO; the head entry is read straight from registered storage.
module dp_ram_initiator_fifo
  import dp_ram_initiator_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  rsp_t                         push_data_i,
  input  logic                         pop_i,
  output rsp_t                         pop_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  rsp_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = count_q == FULL_CNT;
  assign empty_o    = count_q == '0;
  assign count_o    = count_q;

  // Credit accounting upstream must keep a push from ever landing on a full FIFO.
  assert property (@(posedge clk_i) disable iff (rst_i) push_i |-> (!full_o || pop_i));

endmodule

// File: rtl/dp_ram_initiator.sv
// Port-B bus initiator: lane-aligns sized load/store commands onto the byte RAM and
// returns one in-order response per command after the RAM's one-cycle read latency.
module dp_ram_initiator
  import dp_ram_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [1:0]            cmd_size_i,
  input  logic                  cmd_signed_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [31:0]           txn_count_o
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW+1)'(RSP_DEPTH);

  logic          accept;
  logic          cmd_mis;
  logic [1:0]    cmd_off;
  logic          pending_q, pending_d;
  pending_t      pend_q, pend_d;
  logic [31:0]   txn_q, txn_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_flight;
  logic          fifo_full, fifo_empty, pop;
  rsp_t          push_rsp, head_rsp;

  assign cmd_off   = cmd_addr_i[1:0];
  assign cmd_mis   = is_misaligned(cmd_size_i, cmd_off);

  // A pop in the same cycle is not credited back, which keeps ready off the pop path.
  assign in_flight   = {1'b0, fifo_count} + {{CW{1'b0}}, pending_q};
  assign cmd_ready_o = !rst_i && !fifo_full && (in_flight < CREDITS);
  assign accept      = cmd_valid_i && cmd_ready_o;

  assign mem_en_o    = accept && !cmd_mis;
  assign mem_we_o    = cmd_we_i;
  assign mem_be_o    = be_gen(cmd_size_i, cmd_off);
  assign mem_addr_o  = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata_o = cmd_we_i ? wdata_rep(cmd_size_i, cmd_wdata_i) : 32'h0;

  always_comb begin
    pending_d = accept;
    pend_d    = pend_q;
    txn_d     = txn_q;
    if (accept) begin
      pend_d = '{we: cmd_we_i, size: cmd_size_i, sext: cmd_signed_i, off: cmd_off, err: cmd_mis};
      txn_d  = txn_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      pend_q    <= '0;
      txn_q     <= '0;
    end else begin
      pending_q <= pending_d;
      pend_q    <= pend_d;
      txn_q     <= txn_d;
    end
  end

  always_comb begin
    push_rsp = '0;
    if (pend_q.err)     push_rsp.err   = 1'b1;
    else if (!pend_q.we) push_rsp.rdata = rdata_ext(pend_q.size, pend_q.sext, pend_q.off, mem_rdata_i);
  end

  assign pop = rsp_valid_o && rsp_ready_i;

  dp_ram_initiator_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (pending_q),
    .push_data_i (push_rsp),
    .pop_i       (pop),
    .pop_data_o  (head_rsp),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rsp_valid_o = !rst_i && !fifo_empty;
  assign rsp_rdata_o = rsp_valid_o ? head_rsp.rdata : 32'h0;
  assign rsp_err_o   = rsp_valid_o && head_rsp.err;
  assign txn_count_o = rst_i ? 32'h0 : txn_q;

endmodule
